i2c_master_nbyte: RTL
=====================

# i2c_master_nbyte

Parametrised I2C master (single-master, 7-bit addressing) for multi-byte write and read transactions. It generates SCL from the system clock, drives open-drain SCL/SDA through output enables, and checks slave ACKs. A valid/ready-style handshake accepts one command per transaction. It sits between the control logic and the board I2C pads (external pull-ups, tristate buffers in the top level).

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-period; SCL period = 4·`CLK_DIV` cycles; legal values ≥ 2.
- `NBYTES`, default 1: data bytes per transaction; legal range 1..16.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  command request; accepted only when `busy`=0.
- `addr`  in  7  slave address.
- `rw`  in  1  0 = write, 1 = read.
- `data_wr`  in  8·NBYTES  write payload; byte 0 is bits [8·NBYTES-1 -: 8]; sent MSB first.
- `data_rd`  out  8·NBYTES  read payload, same byte order; valid when `done`=1.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `ack_err`  out  1  slave NACKed the last transaction; held until the next accepted `start`.
- `state`  out  3  current FSM state (debug).
- `scl_oe`, `sda_oe`  out  1 each  1 = pull the line low, 0 = release it.
- `scl_in`, `sda_in`  in  1 each  sampled pad levels; already synchronised in the top level.

## Operation
- States:
  - IDLE = 0
  - START = 1
  - ADDR = 2
  - ADDR_ACK = 3
  - DATA = 4
  - DATA_ACK = 5
  - STOP = 6
- Every state spends one or more bit slots. Each slot is 4 quarters, Q0–Q3, of `CLK_DIV` cycles each.
- In ADDR/DATA/ACK slots:
  - SCL is low in Q0–Q1 and released in Q2–Q3.
  - SDA changes only at Q0 entry.
  - SDA is sampled on the last cycle of Q2.
- IDLE: both lines released.
  - `start`=1 latches `addr`, `rw`, `data_wr`, clears `ack_err`, sets `busy`, and moves to START.
- START, one slot: SDA released in Q0–Q1, driven low in Q2–Q3; SCL released throughout.
- ADDR, 8 slots: sends {addr, rw} MSB first.
- ADDR_ACK, 1 slot: SDA released.
  - Sampled 0: go to DATA.
  - Sampled 1: set `ack_err` and go to STOP.
- DATA, 8 slots per byte.
  - Write: master drives the bits.
  - Read: SDA released; sampled bits shift into the current `data_rd` byte.
- DATA_ACK, 1 slot.
  - Write: sample the slave ACK. NACK sets `ack_err` and goes to STOP. ACK goes to DATA for the next byte, or to STOP after byte NBYTES-1.
  - Read: master drives ACK (SDA low) for bytes 0..NBYTES-2 and NACK (released) for the last byte, then goes to STOP.
- STOP, one slot:
  - Q0–Q1: SCL low, SDA low.
  - Q2: SCL released, SDA low.
  - Q3: both released.
  - At the end of Q3: go to IDLE, pulse `done`, clear `busy`.
- Counters:
  - Bit counter 3 bits, counting 7 down to 0.
  - Byte counter width $clog2(NBYTES+1); no wrap past NBYTES-1.
  - Quarter divider counts 0..CLK_DIV-1.
- `start` while `busy`=1 is ignored; no queueing.

## Timing
- Reset values:
  - `scl_oe`=0, `sda_oe`=0
  - `busy`=0, `done`=0, `ack_err`=0
  - `data_rd`=0
  - `state`=IDLE
  - all counters 0
- Assertion of `reset` mid-transaction releases both lines on the same clock edge; no STOP is generated.
- `busy` rises on the cycle after `start` is sampled.
- START Q0 begins on that same cycle.
- Full transaction length = (2 + 9 + 9·NBYTES) slots × 4·`CLK_DIV` cycles, measured from the `busy` rise to the `done` pulse.
- NACK-aborted transactions skip the remaining slots and go straight to STOP.
- `done` and the `busy` fall occur on the same cycle.
- `data_rd` and `ack_err` are stable from the `done` cycle until the next accepted `start`.
- `start` on the same cycle as `done` is ignored. A new command is accepted one cycle later.

## Configuration
- `I2C_CLK_STRETCH_EN` defined:
  - In Q2 of any slot, the quarter divider holds while `scl_in`=0 with `scl_oe`=0 (slave stretching).
  - Counting resumes on the cycle after `scl_in` reads 1.
  - There is no timeout.
- Undefined: `scl_in` is ignored and slot timing is fixed.

## Test plan
- Write, CLK_DIV=2, NBYTES=1, addr=0x50, data 0xA5, slave ACKs all → SDA shows 0xA0, ACK, 0xA5, ACK, STOP. `done` pulses 160 cycles after the `busy` rise; `ack_err`=0.
- Address NACK: addr=0x3C, `sda_in` held 1 → `ack_err`=1 after ADDR_ACK, then straight to STOP. `done` occurs at (2+9)·8 = 88 cycles; no data bits are driven.
- Read, NBYTES=2, slave returns 0x12 then 0x34 → `data_rd`=0x1234. Master ACKs byte 0 and NACKs byte 1.
- `start` pulsed while `busy` → transaction unchanged and no second `done`. `start` on the `done` cycle is ignored.
- `reset` asserted in DATA bit 3 → same edge: `scl_oe`=`sda_oe`=0, `busy`=0, `state`=0. After release, a fresh write completes normally.
- With `I2C_CLK_STRETCH_EN`: slave holds `scl_in` low for 20 cycles in ADDR bit 0 → transaction is 20 cycles longer and data is intact. Without the macro → length is unchanged.

Source files
------------

// File: rtl/i2c_master_nbyte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_master_nbyte                                              |
// | Brief    : Single-master 7-bit I2C master, NBYTES write/read per command; |
// |            define I2C_CLK_STRETCH_EN to honour slave clock stretching.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module i2c_master_nbyte #(
   parameter int CLK_DIV = 4,
   parameter int NBYTES  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [6:0]          addr,
   input  logic                rw,
   input  logic [8*NBYTES-1:0] data_wr,
   output logic [8*NBYTES-1:0] data_rd,
   output logic                busy,
   output logic                done,
   output logic                ack_err,
   output logic [2:0]          state,
   output logic                scl_oe,
   output logic                sda_oe,
   input  logic                scl_in,
   input  logic                sda_in
);

   localparam int QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(NBYTES + 1);
   localparam int IW = $clog2(8 * NBYTES);

   localparam logic [QW-1:0] c_DIV_LAST  = QW'(CLK_DIV - 1);
   localparam logic [BW-1:0] c_LAST_BYTE = BW'(NBYTES - 1);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_START    = 3'd1;
   localparam logic [2:0] c_ADDR     = 3'd2;
   localparam logic [2:0] c_ADDR_ACK = 3'd3;
   localparam logic [2:0] c_DATA     = 3'd4;
   localparam logic [2:0] c_DATA_ACK = 3'd5;
   localparam logic [2:0] c_STOP     = 3'd6;

   logic [2:0]          r_state;
   logic [1:0]          r_quarter;
   logic [QW-1:0]       r_qdiv;
   logic [2:0]          r_bit_cnt;
   logic [BW-1:0]       r_byte_cnt;
   logic [7:0]          r_addr_rw;
   logic [8*NBYTES-1:0] r_data_wr;
   logic [8*NBYTES-1:0] r_data_rd;
   logic                r_ack_bit;
   logic                r_busy;
   logic                r_done;
   logic                r_ack_err;
   logic                r_scl_oe;
   logic                r_sda_oe;

   logic [2:0]          w_state_nxt;
   logic [1:0]          w_quarter_nxt;
   logic [QW-1:0]       w_qdiv_nxt;
   logic [2:0]          w_bit_nxt;
   logic [BW-1:0]       w_byte_nxt;
   logic                w_scl_oe_nxt;
   logic                w_sda_oe_nxt;
   logic [IW-1:0]       w_tx_idx;
   logic [IW-1:0]       w_rx_idx;
   logic                w_accept;
   logic                w_tick;
   logic                w_sample;
   logic                w_slot_end;
   logic                w_last_byte;
   logic                w_rd;
   logic                w_nack_abort;

   // A command arriving in the done cycle is dropped, not deferred.
   assign w_accept = (r_state == c_IDLE) && start && !r_done;

`ifdef I2C_CLK_STRETCH_EN
   assign w_tick = !((r_quarter == 2'd2) && !r_scl_oe && !scl_in);
`else
   logic w_unused_scl;
   assign w_unused_scl = scl_in;
   assign w_tick       = 1'b1;
`endif

   assign w_sample     = (r_state != c_IDLE) && w_tick && (r_quarter == 2'd2) && (r_qdiv == c_DIV_LAST);
   assign w_slot_end   = (r_state != c_IDLE) && w_tick && (r_quarter == 2'd3) && (r_qdiv == c_DIV_LAST);
   assign w_last_byte  = (r_byte_cnt == c_LAST_BYTE);
   assign w_rd         = r_addr_rw[0];
   assign w_nack_abort = w_slot_end && r_ack_bit &&
                         ((r_state == c_ADDR_ACK) || ((r_state == c_DATA_ACK) && !w_rd));
   assign w_rx_idx     = IW'(8 * (NBYTES - 1 - int'(r_byte_cnt)) + int'(r_bit_cnt));

   always_comb begin
      w_state_nxt   = r_state;
      w_quarter_nxt = r_quarter;
      w_qdiv_nxt    = r_qdiv;
      w_bit_nxt     = r_bit_cnt;
      w_byte_nxt    = r_byte_cnt;
      if (r_state == c_IDLE) begin
         if (w_accept) begin
            w_state_nxt   = c_START;
            w_quarter_nxt = 2'd0;
            w_qdiv_nxt    = '0;
            w_bit_nxt     = 3'd0;
            w_byte_nxt    = '0;
         end
      end else if (w_tick) begin
         if (r_qdiv == c_DIV_LAST) begin
            w_qdiv_nxt    = '0;
            w_quarter_nxt = r_quarter + 2'd1;
         end else begin
            w_qdiv_nxt = r_qdiv + QW'(1);
         end
         if (w_slot_end) begin
            case (r_state)
               c_START: begin
                  w_state_nxt = c_ADDR;
                  w_bit_nxt   = 3'd7;
               end
               c_ADDR: begin
                  if (r_bit_cnt == 3'd0) w_state_nxt = c_ADDR_ACK;
                  else                   w_bit_nxt   = r_bit_cnt - 3'd1;
               end
               c_ADDR_ACK: begin
                  if (r_ack_bit) begin
                     w_state_nxt = c_STOP;
                  end else begin
                     w_state_nxt = c_DATA;
                     w_bit_nxt   = 3'd7;
                     w_byte_nxt  = '0;
                  end
               end
               c_DATA: begin
                  if (r_bit_cnt == 3'd0) w_state_nxt = c_DATA_ACK;
                  else                   w_bit_nxt   = r_bit_cnt - 3'd1;
               end
               c_DATA_ACK: begin
                  if (w_nack_abort || w_last_byte) begin
                     w_state_nxt = c_STOP;
                  end else begin
                     w_state_nxt = c_DATA;
                     w_bit_nxt   = 3'd7;
                     w_byte_nxt  = r_byte_cnt + BW'(1);
                  end
               end
               c_STOP: begin
                  w_state_nxt = c_IDLE;
                  w_byte_nxt  = '0;
               end
               default: w_state_nxt = c_IDLE;
            endcase
         end
      end
   end

   // Pad enables are registered from the upcoming slot position so they leave the flop glitch-free.
   always_comb begin
      w_tx_idx     = IW'(8 * (NBYTES - 1 - int'(w_byte_nxt)) + int'(w_bit_nxt));
      w_scl_oe_nxt = 1'b0;
      w_sda_oe_nxt = 1'b0;
      case (w_state_nxt)
         c_START: begin
            w_sda_oe_nxt = w_quarter_nxt[1];
         end
         c_ADDR: begin
            w_scl_oe_nxt = !w_quarter_nxt[1];
            w_sda_oe_nxt = !r_addr_rw[w_bit_nxt];
         end
         c_ADDR_ACK: begin
            w_scl_oe_nxt = !w_quarter_nxt[1];
         end
         c_DATA: begin
            w_scl_oe_nxt = !w_quarter_nxt[1];
            w_sda_oe_nxt = !w_rd && !r_data_wr[w_tx_idx];
         end
         c_DATA_ACK: begin
            w_scl_oe_nxt = !w_quarter_nxt[1];
            w_sda_oe_nxt = w_rd && (w_byte_nxt != c_LAST_BYTE);
         end
         c_STOP: begin
            w_scl_oe_nxt = !w_quarter_nxt[1];
            w_sda_oe_nxt = (w_quarter_nxt != 2'd3);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= c_IDLE;
         r_quarter  <= 2'd0;
         r_qdiv     <= '0;
         r_bit_cnt  <= 3'd0;
         r_byte_cnt <= '0;
         r_addr_rw  <= 8'd0;
         r_data_wr  <= '0;
         r_data_rd  <= '0;
         r_ack_bit  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ack_err  <= 1'b0;
         r_scl_oe   <= 1'b0;
         r_sda_oe   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_quarter  <= w_quarter_nxt;
         r_qdiv     <= w_qdiv_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_byte_cnt <= w_byte_nxt;
         r_scl_oe   <= w_scl_oe_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_done     <= 1'b0;
         if (w_accept) begin
            r_addr_rw <= {addr, rw};
            r_data_wr <= data_wr;
            r_ack_err <= 1'b0;
            r_busy    <= 1'b1;
         end
         if (w_sample) begin
            r_ack_bit <= sda_in;
            if ((r_state == c_DATA) && w_rd) r_data_rd[w_rx_idx] <= sda_in;
         end
         if (w_nack_abort) r_ack_err <= 1'b1;
         if (w_slot_end && (r_state == c_STOP)) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   assign data_rd = r_data_rd;
   assign busy    = r_busy;
   assign done    = r_done;
   assign ack_err = r_ack_err;
   assign state   = r_state;
   assign scl_oe  = r_scl_oe;
   assign sda_oe  = r_sda_oe;

endmodule
`default_nettype wire
